apb_master: RTL

APB initiator that turns single host-side read/write commands into APB transfers toward the I2C controller's APB register slave. Each command goes through the standard IDLE → SETUP → ACCESS sequence and waits for the slave's PREADY. The read data or a timeout error is then returned to the host as a one-cycle response pulse. The block sits between the system/host logic and the APB slave, and completes the APB link from the requester side.

---
 rtl/apb_master_if.sv | 37 +++
 rtl/apb_master.sv | 98 +++++++++
 2 files changed

// File: rtl/apb_master_if.sv
// Host command/response and APB signal bundle for apb_master.
// The master modport is the initiator's view; slave is the host/APB-slave side.
interface apb_master_if #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 8
) ();

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_error;
  logic                  busy;
  logic                  PSELx;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  PREADY;
  logic [DATA_WIDTH-1:0] PRDATA;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PREADY, PRDATA,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error, busy,
           PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PREADY, PRDATA,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, busy,
           PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );

endinterface

// File: rtl/apb_master.sv
// APB initiator: one host command becomes one IDLE->SETUP->ACCESS transfer, answered by a
// single-cycle response pulse carrying read data or a timeout error.
module apb_master #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 16
) (
  input logic          PCLK,
  input logic          PRESET,
  apb_master_if.master bus_io
);

  localparam int unsigned     CntW       = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e                state_q;
  logic [CntW-1:0]       wait_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic                  rsp_valid_q;
  logic                  rsp_error_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= StIdle;
      wait_q      <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus_io.cmd_valid) begin
            pwrite_q <= bus_io.cmd_write;
            paddr_q  <= bus_io.cmd_addr;
            pwdata_q <= bus_io.cmd_wdata;
            psel_q   <= 1'b1;
            wait_q   <= '0;
            state_q  <= StSetup;
          end
        end
        StSetup: begin
          penable_q <= 1'b1;
          state_q   <= StAccess;
        end
        StAccess: begin
          // Completion is checked first so PREADY at the timeout count still wins.
          if (bus_io.PREADY) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= pwrite_q ? '0 : bus_io.PRDATA;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state_q     <= StIdle;
          end else if ((TIMEOUT != 0) && (wait_q == TimeoutCnt)) begin
            rsp_valid_q <= 1'b1;
            rsp_error_q <= 1'b1;
            rsp_rdata_q <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state_q     <= StIdle;
          end else if (TIMEOUT != 0) begin
            wait_q <= wait_q + 1'b1;
          end
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

  assign bus_io.cmd_ready = (state_q == StIdle);
  assign bus_io.busy      = (state_q != StIdle);
  assign bus_io.PSELx     = psel_q;
  assign bus_io.PENABLE   = penable_q;
  assign bus_io.PWRITE    = pwrite_q;
  assign bus_io.PADDR     = paddr_q;
  assign bus_io.PWDATA    = pwdata_q;
  assign bus_io.rsp_valid = rsp_valid_q;
  assign bus_io.rsp_error = rsp_error_q;
  assign bus_io.rsp_rdata = rsp_rdata_q;

endmodule
